// File: rtl/aes_host_pkg.sv
// Shared constants, types and helpers for the AES register-port host driver.
package aes_host_pkg;

  localparam logic [6:0] TEXT_BASE = 7'h00;
  localparam logic [6:0] RES_BASE  = 7'h10;
  localparam logic [6:0] KEY_BASE  = 7'h20;
  localparam logic [6:0] ADDR_OP   = 7'h40;
  localparam logic [6:0] ADDR_NK   = 7'h41;
  localparam logic [6:0] ADDR_STAT = 7'h42;

  localparam logic [2:0] NK_128 = 3'd3;
  localparam logic [2:0] NK_192 = 3'd5;
  localparam logic [2:0] NK_256 = 3'd7;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_TIMEOUT = 2'd1,
    RSP_BAD_NK  = 2'd2
  } rsp_status_e;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_WR_CFG   = 4'd1,
    S_WR_TEXT  = 4'd2,
    S_WR_KEY   = 4'd3,
    S_POLL     = 4'd4,
    S_START    = 4'd5,
    S_WAIT_LOW = 4'd6,
    S_WAIT_OK  = 4'd7,
    S_READ     = 4'd8,
    S_RSP      = 4'd9
  } state_e;

  // Key length in bytes for an NK code; zero marks an unsupported code.
  function automatic logic [5:0] nk_to_bytes(input logic [2:0] nk);
    logic [5:0] n;
    case (nk)
      NK_128:  n = 6'd16;
      NK_192:  n = 6'd24;
      NK_256:  n = 6'd32;
      default: n = 6'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/aes_host_if.sv
// Request/response handshake plus the AES byte-wide register bus.
interface aes_host_if;
  import aes_host_pkg::*;

  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_text;
  logic [255:0] req_key;
  logic [2:0]   req_nk;
  logic         req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_data;
  rsp_status_e  rsp_status;
  logic [7:0]   DIN;
  logic [6:0]   ADDR;
  logic         WR;
  logic         START;
  logic         OK;
  logic [7:0]   DOUT;

  modport master (
    input  req_valid, req_text, req_key, req_nk, req_op, rsp_ready, OK, DOUT,
    output req_ready, rsp_valid, rsp_data, rsp_status, DIN, ADDR, WR, START
  );

  modport slave (
    output req_valid, req_text, req_key, req_nk, req_op, rsp_ready, OK, DOUT,
    input  req_ready, rsp_valid, rsp_data, rsp_status, DIN, ADDR, WR, START
  );

endinterface

// File: rtl/aes_host_timer.sv
// Saturating cycle counter; done_o flags the cycle in which the count steps onto LIMIT.
module aes_host_timer #(
  parameter int LIMIT = 65535,
  parameter int TW    = 16
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [TW-1:0] LIMIT_C = TW'(LIMIT);
  localparam logic [TW-1:0] LAST_C  = TW'(LIMIT - 1);
  localparam logic [TW-1:0] ONE_C   = TW'(1);

  logic [TW-1:0] cnt_q;

  // Count enabled cycles since the last clear, holding at the limit.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      cnt_q <= {TW{1'b0}};
    end else if (clr_i) begin
      cnt_q <= {TW{1'b0}};
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_q <= cnt_q + ONE_C;
    end
  end

  assign done_o = (cnt_q >= LAST_C);

endmodule

// File: rtl/aes_host_driver.sv
// Host-side sequencer: one request becomes config/text/key writes, status polling,
// a START pulse, an OK wait and a pipelined 16-byte result readback.
module aes_host_driver
  import aes_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TW             = 16
) (
  input  logic        CLK,
  input  logic        RSTB,
  aes_host_if.master  bus
);

  state_e       state_q;
  logic [5:0]   idx_q;
  logic [5:0]   nbytes_q;
  logic [2:0]   nk_q;
  logic [127:0] text_q;
  logic [255:0] key_q;
  logic         req_ready_q;
  logic         rsp_valid_q;
  logic [127:0] rsp_data_q;
  rsp_status_e  rsp_status_q;
  logic [7:0]   din_q;
  logic [6:0]   addr_q;
  logic         wr_q;
  logic         start_q;

  logic [5:0]   idx_inc_s;
  logic         tmr_en_s;
  logic         tmr_clr_s;
  logic         waiting_s;
  logic         tmr_done_s;

  assign idx_inc_s = idx_q + 6'd1;

  // Timeout window opens on the first poll and covers the whole status/OK wait.
  always_comb begin
    tmr_en_s  = 1'b0;
    tmr_clr_s = 1'b0;
    waiting_s = 1'b0;
    case (state_q)
      S_POLL, S_WAIT_LOW, S_WAIT_OK: begin
        tmr_en_s  = 1'b1;
        waiting_s = 1'b1;
      end
      S_START:  tmr_en_s  = 1'b1;
      S_WR_KEY: tmr_clr_s = (idx_q == (nbytes_q - 6'd1));
      default:  tmr_en_s  = 1'b0;
    endcase
  end

  aes_host_timer #(.LIMIT(TIMEOUT_CYCLES), .TW(TW)) u_timer (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .clr_i  (tmr_clr_s),
    .en_i   (tmr_en_s),
    .done_o (tmr_done_s)
  );

  // Transaction sequencer; every bus and handshake output is registered here.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q      <= S_IDLE;
      idx_q        <= 6'd0;
      nbytes_q     <= 6'd0;
      nk_q         <= 3'd0;
      text_q       <= 128'd0;
      key_q        <= 256'd0;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 128'd0;
      rsp_status_q <= RSP_OK;
      din_q        <= 8'd0;
      addr_q       <= 7'd0;
      wr_q         <= 1'b0;
      start_q      <= 1'b0;
    end else if (waiting_s && tmr_done_s) begin
      state_q      <= S_RSP;
      rsp_valid_q  <= 1'b1;
      rsp_status_q <= RSP_TIMEOUT;
      rsp_data_q   <= 128'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_ready_q && bus.req_valid) begin
            req_ready_q <= 1'b0;
            text_q      <= bus.req_text;
            key_q       <= bus.req_key;
            nk_q        <= bus.req_nk;
            nbytes_q    <= nk_to_bytes(bus.req_nk);
            idx_q       <= 6'd0;
            if (nk_to_bytes(bus.req_nk) == 6'd0) begin
              state_q      <= S_RSP;
              rsp_valid_q  <= 1'b1;
              rsp_status_q <= RSP_BAD_NK;
              rsp_data_q   <= 128'd0;
            end else begin
              state_q <= S_WR_CFG;
              wr_q    <= 1'b1;
              addr_q  <= ADDR_OP;
              din_q   <= {7'd0, bus.req_op};
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WR_CFG: begin
          if (idx_q == 6'd0) begin
            addr_q <= ADDR_NK;
            din_q  <= {5'd0, nk_q};
            idx_q  <= 6'd1;
          end else begin
            state_q <= S_WR_TEXT;
            addr_q  <= TEXT_BASE;
            din_q   <= text_q[7:0];
            idx_q   <= 6'd0;
          end
        end
        S_WR_TEXT: begin
          if (idx_q == 6'd15) begin
            state_q <= S_WR_KEY;
            addr_q  <= KEY_BASE;
            din_q   <= key_q[7:0];
            idx_q   <= 6'd0;
          end else begin
            addr_q <= TEXT_BASE + {1'b0, idx_inc_s};
            din_q  <= text_q[{idx_inc_s[3:0], 3'b000} +: 8];
            idx_q  <= idx_inc_s;
          end
        end
        S_WR_KEY: begin
          if (idx_q == (nbytes_q - 6'd1)) begin
            state_q <= S_POLL;
            wr_q    <= 1'b0;
            din_q   <= 8'd0;
            addr_q  <= ADDR_STAT;
            idx_q   <= 6'd0;
          end else begin
            addr_q <= KEY_BASE + {1'b0, idx_inc_s};
            din_q  <= key_q[{idx_inc_s[4:0], 3'b000} +: 8];
            idx_q  <= idx_inc_s;
          end
        end
        S_POLL: begin
          // DOUT reflects the status register only in the second poll cycle.
          if (idx_q == 6'd0) begin
            idx_q <= 6'd1;
          end else if (bus.DOUT[0]) begin
            idx_q <= 6'd0;
          end else begin
            state_q <= S_START;
            start_q <= 1'b1;
          end
        end
        S_START: begin
          start_q <= 1'b0;
          state_q <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!bus.OK) begin
            state_q <= S_WAIT_OK;
          end
        end
        S_WAIT_OK: begin
          if (bus.OK) begin
            state_q <= S_READ;
            addr_q  <= RES_BASE;
            idx_q   <= 6'd0;
          end
        end
        S_READ: begin
          if (idx_q != 6'd0) begin
            rsp_data_q <= {bus.DOUT, rsp_data_q[127:8]};
          end
          if (idx_q == 6'd16) begin
            state_q      <= S_RSP;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= RSP_OK;
          end else begin
            if (idx_q < 6'd15) begin
              addr_q <= RES_BASE + {1'b0, idx_inc_s};
            end
            idx_q <= idx_inc_s;
          end
        end
        S_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.DIN        = din_q;
  assign bus.ADDR       = addr_q;
  assign bus.WR         = wr_q;
  assign bus.START      = start_q;

endmodule

// File: tb/tb_aes_host_driver.sv
// Bench for aes_host_driver: a behavioural register responder plus a table of
// requests whose expected writes, polls and responses are derived from the address map.
module tb_aes_host_driver;
  import aes_host_pkg::*;

  localparam int TO = 100;

  logic clk;
  logic rstb;
  aes_host_if bus();

  aes_host_driver #(.TIMEOUT_CYCLES(TO), .TW(16)) dut (
    .CLK  (clk),
    .RSTB (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Responder configuration, set per request by the stimulus.
  int         busy_polls = 0;
  int         ok_dly = 1;
  logic [7:0] res_bytes [16];

  // Responder observations.
  logic [14:0] wr_log[$];
  int          start_cnt = 0;
  int          poll_total = 0;
  int          poll_run = 0;
  int          poll_start_cyc = 0;
  int          ok_cnt = 0;
  logic        armed = 1'b0;
  logic        ok_r = 1'b0;
  logic [7:0]  dout_r = 8'h00;

  assign bus.OK   = ok_r;
  assign bus.DOUT = dout_r;

  // Register responder: logs writes, reports core-full for busy_polls polls, raises OK after START.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.WR) begin
      wr_log.push_back({bus.ADDR, bus.DIN});
      armed    <= 1'b1;
      poll_run <= 0;
    end else if (bus.START) begin
      armed <= 1'b0;
    end
    if (!bus.WR && !bus.START && armed && bus.ADDR == ADDR_STAT) begin
      if (poll_run == 0) poll_start_cyc <= cyc;
      poll_run   <= poll_run + 1;
      poll_total <= poll_total + 1;
      dout_r     <= {7'd0, ((poll_run + 1) < 2 * busy_polls)};
    end else if (bus.ADDR >= RES_BASE && bus.ADDR < KEY_BASE) begin
      dout_r <= res_bytes[bus.ADDR[3:0]];
    end else begin
      dout_r <= 8'h00;
    end
    if (bus.START) begin
      start_cnt <= start_cnt + 1;
      ok_r      <= 1'b0;
      ok_cnt    <= ok_dly;
    end else if (ok_cnt > 0) begin
      ok_cnt <= ok_cnt - 1;
      if (ok_cnt == 1) ok_r <= 1'b1;
    end
  end

  typedef struct {
    logic [127:0] text;
    logic [255:0] key;
    logic [2:0]   nk;
    logic         op;
    int           busy;
    int           okd;
    logic [127:0] result;
    int           hold;
    logic [127:0] exp_data;
    logic [1:0]   exp_status;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int key_len(input logic [2:0] nk);
    if (nk == 3'd3) return 16;
    if (nk == 3'd5) return 24;
    if (nk == 3'd7) return 32;
    return 0;
  endfunction

  function automatic vec_t mkvec(input logic [127:0] text, input logic [255:0] key,
                                 input logic [2:0] nk, input logic op, input int busy,
                                 input int okd, input logic [127:0] result, input int hold);
    vec_t v;
    v.text = text; v.key = key; v.nk = nk; v.op = op;
    v.busy = busy; v.okd = okd; v.result = result; v.hold = hold;
    if (key_len(nk) == 0) v.exp_status = 2'd2;
    else if (okd < 0)     v.exp_status = 2'd1;
    else                  v.exp_status = 2'd0;
    v.exp_data = (v.exp_status == 2'd0) ? result : 128'd0;
    return v;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_responder(input vec_t v);
    busy_polls = v.busy;
    ok_dly     = v.okd;
    for (int i = 0; i < 16; i++) res_bytes[i] = v.result[8*i +: 8];
  endtask

  task automatic send_req(input vec_t v);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", bus.req_ready, 1);
    bus.req_text  = v.text;
    bus.req_key   = v.key;
    bus.req_nk    = v.nk;
    bus.req_op    = v.op;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("req_ready_drop", bus.req_ready, 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n, wr0, st0, pt0, nb, bad, lat;
    logic [14:0] expw[$];
    logic [127:0] d0;
    load_responder(v);
    wr0 = wr_log.size();
    st0 = start_cnt;
    pt0 = poll_total;
    send_req(v);
    n = 0;
    while (!bus.rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) begin
      chk({nm, "_rsp_timeout"}, 0, 1);
      return;
    end
    lat = cyc - poll_start_cyc;
    chk({nm, "_status"}, bus.rsp_status, v.exp_status);
    if (v.exp_status != 2'd2) chk({nm, "_data"}, bus.rsp_data, v.exp_data);
    // Expected write sequence straight from the register map.
    nb = key_len(v.nk);
    if (nb != 0) begin
      expw.push_back({ADDR_OP, 7'd0, v.op});
      expw.push_back({ADDR_NK, 5'd0, v.nk});
      for (int k = 0; k < 16; k++) expw.push_back({7'(k), v.text[8*k +: 8]});
      for (int k = 0; k < nb; k++) expw.push_back({7'(32 + k), v.key[8*k +: 8]});
    end
    chk({nm, "_wr_count"}, wr_log.size() - wr0, expw.size());
    if (expw.size() != 0 && wr_log.size() - wr0 == expw.size()) begin
      bad = expw.size() - 1;
      for (int k = expw.size() - 1; k >= 0; k--) begin
        if (wr_log[wr0 + k] !== expw[k]) bad = k;
      end
      chk({nm, "_wr_entry"}, wr_log[wr0 + bad], expw[bad]);
    end
    chk({nm, "_starts"}, start_cnt - st0, (nb == 0) ? 0 : 1);
    chk({nm, "_poll_cycles"}, poll_total - pt0, (nb == 0) ? 0 : 2 * (v.busy + 1));
    if (v.exp_status == 2'd1) chk({nm, "_timeout_latency_in_window"}, (lat <= TO && lat >= TO - 4), 1);
    d0 = bus.rsp_data;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk({nm, "_rsp_hold"}, {bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready},
          {1'b1, d0, v.exp_status, 1'b0});
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, "_rsp_done"}, {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_status,
             bus.DIN, bus.ADDR, bus.WR, bus.START}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n, wr0;
    logic [2:0] nks [6];
    nks[0] = 3'd3; nks[1] = 3'd5; nks[2] = 3'd7; nks[3] = 3'd3; nks[4] = 3'd7; nks[5] = 3'd0;

    bus.req_valid = 1'b0;
    bus.req_text  = 128'd0;
    bus.req_key   = 256'd0;
    bus.req_nk    = 3'd0;
    bus.req_op    = 1'b0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 16; i++) res_bytes[i] = 8'h00;

    tbl.push_back(mkvec(128'h0f0e0d0c0b0a09080706050403020100,
                        {128'd0, 128'h1f1e1d1c1b1a19181716151413121110},
                        3'd3, 1'b1, 0, 2, 128'hafaeadacabaaa9a8a7a6a5a4a3a2a1a0, 0));
    tbl.push_back(mkvec(r128(), {r128(), r128()}, 3'd7, 1'b0, 1, 3, r128(), 2));
    tbl.push_back(mkvec(r128(), {r128(), r128()}, 3'd5, 1'b1, 0, 1, r128(), 0));
    tbl.push_back(mkvec(r128(), {r128(), r128()}, 3'd3, 1'b1, 3, 4, r128(), 1));
    tbl.push_back(mkvec(r128(), {r128(), r128()}, 3'd3, 1'b0, 0, -1, r128(), 1));
    tbl.push_back(mkvec(r128(), {r128(), r128()}, 3'd4, 1'b1, 0, 2, r128(), 5));

    rstb = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rstb = 1'b1;
    #1;
    chk("ready_at_release", bus.req_ready, 0);
    @(negedge clk);
    chk("ready_after_release", bus.req_ready, 1);

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("dir%0d", i));

    // Reset in the middle of the key writes, then a clean transaction.
    v = mkvec(r128(), {r128(), r128()}, 3'd7, 1'b1, 0, 2, r128(), 0);
    load_responder(v);
    wr0 = wr_log.size();
    send_req(v);
    n = 0;
    while (wr_log.size() - wr0 < 25 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_key_reached", wr_log.size() - wr0 >= 25, 1);
    #2 rstb = 1'b0;
    #1 chk_all_zero("midtxn_reset_outputs");
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    #1 chk("midtxn_ready_at_release", bus.req_ready, 0);
    @(negedge clk);
    chk("midtxn_ready_after_release", bus.req_ready, 1);
    run_vec(mkvec(r128(), {r128(), r128()}, 3'd3, 1'b1, 1, 2, r128(), 0), "after_reset");

    for (int i = 0; i < 20; i++) begin
      v = mkvec(r128(), {r128(), r128()}, nks[$urandom_range(5, 0)], 1'($urandom_range(1, 0)),
                int'($urandom_range(2, 0)), int'($urandom_range(6, 1)), r128(),
                int'($urandom_range(3, 0)));
      if (v.nk == 3'd0) v = mkvec(v.text, v.key, 3'($urandom_range(6, 0) & 3'd6), v.op,
                                 v.busy, v.okd, v.result, v.hold);
      run_vec(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_host_driver.md
Name: aes_host_driver

Overview:
Host-side initiator for the AES block's byte-wide register port (DIN/ADDR/WR/START/OK/DOUT). It accepts one request (128-bit text, 256-bit key, NK code, op) over a valid/ready handshake and sequences the full register transaction: config writes, text and key byte writes, core-full polling, START pulse, OK wait and 16-byte result readback. It returns the result over a valid/ready response with a status code. Everything runs in the CLK domain.

Parameters:
TIMEOUT_CYCLES, 65535, max CLK cycles from first status poll to OK=1 before aborting with timeout status
TW, 16, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
CLK  in  1  system clock; all state on posedge
RSTB  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  driver idle, can accept request
req_text  in  128  text; byte k = bits [8k+7:8k]
req_key  in  256  key; byte k = bits [8k+7:8k]
req_nk  in  3  key code: 3=AES-128, 5=AES-192, 7=AES-256
req_op  in  1  1 encrypt, 0 decrypt
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response consumed
rsp_data  out  128  result; byte k = bits [8k+7:8k]
rsp_status  out  2  0 OK, 1 timeout, 2 bad NK
DIN  out  8  write data to interface
ADDR  out  7  register address
WR  out  1  write strobe, one byte per cycle
START  out  1  one-cycle start pulse
OK  in  1  result ready (level; cleared by START)
DOUT  in  8  read data, registered, valid one cycle after ADDR with WR=0

Behaviour:
- Reset: all outputs 0 (req_ready=0, rsp_valid=0, rsp_data=0, rsp_status=0, DIN/ADDR/WR/START=0). FSM returns to IDLE. Reset mid-transaction abandons the transaction without a response.
- Address map: text bytes 0x00-0x0F; result bytes 0x10-0x1F; key bytes 0x20-0x3F; op 0x40 (DIN[0]); NK 0x41 (DIN[2:0]); status 0x42 (DOUT[0]=core full).
- IDLE: req_ready=1 (registered; first high one cycle after RSTB release). On req_valid&&req_ready, capture all req_* and drop req_ready next cycle. If req_nk is not 3/5/7, go to RSP with status 2, no bus activity.
- WR_CFG: 2 cycles, WR=1: ADDR=0x40 DIN={7'b0,op}, then ADDR=0x41 DIN={5'b0,nk}.
- WR_TEXT: 16 cycles, WR=1, ADDR=k, DIN=text byte k, k=0..15.
- WR_KEY: n cycles (n=16/24/32 for nk 3/5/7), WR=1, ADDR=0x20+k, DIN=key byte k. Key bytes beyond n are not written.
- POLL: WR=0, ADDR=0x42 for 2 cycles. Sample DOUT[0] at the end of the 2nd cycle. If 1, repeat POLL. If 0, go to START. Timeout counter clears on entering the first POLL and counts every cycle after that.
- START: START=1 for exactly one cycle, WR=0.
- WAIT_LOW: wait until OK=0 (normally the next cycle). WAIT_OK: wait for OK=1. OK is treated as a level.
- Timeout: if the counter reaches TIMEOUT_CYCLES in POLL/WAIT_LOW/WAIT_OK, go to RSP with status 1 and rsp_data=0.
- READ: pipelined, 17 cycles. Cycle i (0..15) drives WR=0, ADDR=0x10+i. The DOUT present in cycle i+1 is stored as byte i.
- RSP: rsp_valid=1 with data/status stable until rsp_ready. Same cycle rsp_valid&&rsp_ready → IDLE (req_ready=1 next cycle).
- Outside write states: WR=0, DIN=0. ADDR holds its last value except where driven above.
- Bus cycles, AES-128 success path: 34 writes + ≥2 poll + 1 START + waits + 17 read.

Decomposition:
- Package aes_host_pkg: address constants (TEXT_BASE, RES_BASE, KEY_BASE, ADDR_OP, ADDR_NK, ADDR_STAT), NK codes, status codes, FSM state enum, function nk_to_bytes(nk)→6-bit count.
- One sub-module aes_host_timer: clear/enable counter with a done flag at TIMEOUT_CYCLES.
- Byte index counter and shift-in of read data stay in the top module.

Test Plan:
- AES-128 encrypt; bench models the register responder: req_text=128'h0f0e..0100, key=128'h1f1e..10, nk=3, op=1 → writes 0x40←01, 0x41←03, ADDR 0x00-0x0F DIN 00..0f, 0x20-0x2F DIN 10..1f; one START; model returns result bytes a0..af → rsp_data=128'hafae..a0, status 0.
- nk=7 decrypt → exactly 32 key writes ending at ADDR 0x3F; 0x40←00; nk=5 → last key write ADDR 0x37.
- Model holds core-full=1 for 3 polls → 3 repeated 0x42 polls, no START until the 4th poll reads 0.
- OK never rises, TIMEOUT_CYCLES=100 → rsp_valid with status 1 and rsp_data=0 within 100 cycles of the first poll; WR stays 0.
- req_nk=4 → no WR/START activity; rsp_status=2 on the response. Also hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_data stable, req_ready=0.
- Assert RSTB low during WR_KEY → all outputs 0 immediately; after release, req_ready=1 one cycle later and a new request completes normally.
